// File: rtl/map_write_arbiter_if.sv
// Producer and BRAM write-port bundle for map_write_arbiter.
// slave = arbiter side, master = producer/BRAM model side.
interface map_write_arbiter_if #(
  parameter int AW = 19,
  parameter int DW = 8
);
  logic          clear_req;
  logic [AW-1:0] s0_addr;
  logic [DW-1:0] s0_data;
  logic          s0_valid;
  logic          s0_ready;
  logic [AW-1:0] s1_addr;
  logic [DW-1:0] s1_data;
  logic          s1_valid;
  logic          s1_ready;
  logic [AW-1:0] vga_waddr;
  logic [DW-1:0] dina;
  logic          wea;
  logic          ena;
  logic          busy;
  logic [7:0]    drop_count;

  modport slave (
    input  clear_req,
    input  s0_addr, s0_data, s0_valid,
    input  s1_addr, s1_data, s1_valid,
    output s0_ready, s1_ready,
    output vga_waddr, dina, wea, ena,
    output busy, drop_count
  );

  modport master (
    output clear_req,
    output s0_addr, s0_data, s0_valid,
    output s1_addr, s1_data, s1_valid,
    input  s0_ready, s1_ready,
    input  vga_waddr, dina, wea, ena,
    input  busy, drop_count
  );
endinterface

// File: rtl/map_write_arbiter.sv
// Map BRAM write arbiter: sweeps the map to FILL, then round-robins
// two FIFO-buffered producers onto the single BRAM write port.
module map_write_arbiter #(
  parameter int            AW        = 19,
  parameter int            DW        = 8,
  parameter int            MAP_WORDS = 307200,
  parameter logic [DW-1:0] FILL      = 8'hFF,
  parameter int            DEPTH     = 4
) (
  input logic                clk,
  input logic                reset,
  map_write_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [AW:0] LIM = (AW+1)'(MAP_WORDS);
  localparam logic [AW-1:0] LAST = AW'(MAP_WORDS - 1);
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN = 1'b1;

  typedef logic [AW+DW-1:0] ent_t;

  logic [0:0]    state;
  logic [AW-1:0] clear_ptr;
  logic          last_grant;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          wen;
  logic [7:0]    drops;
  logic [8:0]    drop_sum;

  ent_t       mem [2][DEPTH];
  logic [PW:0] wp [2];
  logic [PW:0] rp [2];
  ent_t       in_ent [2];
  ent_t       head [2];
  logic [1:0] in_valid;
  logic [1:0] full;
  logic [1:0] empty;
  logic [1:0] ok;
  logic [1:0] acc;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] drop;

  assign in_ent[0] = {bus.s0_addr, bus.s0_data};
  assign in_ent[1] = {bus.s1_addr, bus.s1_data};
  assign in_valid = {bus.s1_valid, bus.s0_valid};

  always_comb begin
    full = '0;
    empty = '0;
    ok = '0;
    acc = '0;
    for (int i = 0; i < 2; i++) begin
      full[i] = (wp[i] ^ rp[i]) == {1'b1, {PW{1'b0}}};
      empty[i] = wp[i] == rp[i];
      ok[i] = {1'b0, in_ent[i][AW+DW-1:DW]} < LIM;
      acc[i] = in_valid[i] && !full[i];
      head[i] = mem[i][rp[i][PW-1:0]];
    end
  end

  // out-of-range beats are consumed but never reach a FIFO
  assign push = acc & ok;
  assign drop = acc & ~ok;

  assign pop[0] = (state == RUN) && !empty[0]
                  && (empty[1] || last_grant);
  assign pop[1] = (state == RUN) && !empty[1]
                  && (empty[0] || !last_grant);

  assign drop_sum = {1'b0, drops} + 9'(drop[0]) + 9'(drop[1]);

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (push[i]) mem[i][wp[i][PW-1:0]] <= in_ent[i];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        wp[i] <= '0;
        rp[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wp[i] <= wp[i] + (PW+1)'(1);
        if (pop[i]) rp[i] <= rp[i] + (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= CLEAR;
      clear_ptr <= '0;
      last_grant <= 1'b1;
      waddr <= '0;
      wdata <= '0;
      wen <= 1'b0;
      drops <= '0;
    end else begin
      wen <= 1'b0;
      unique case (1'b1)
        state == CLEAR: begin
          wen <= 1'b1;
          waddr <= clear_ptr;
          wdata <= FILL;
          if (clear_ptr == LAST) begin
            state <= RUN;
            clear_ptr <= '0;
          end else begin
            clear_ptr <= clear_ptr + AW'(1);
          end
        end
        pop[0]: begin
          wen <= 1'b1;
          {waddr, wdata} <= head[0];
          last_grant <= 1'b0;
        end
        pop[1]: begin
          wen <= 1'b1;
          {waddr, wdata} <= head[1];
          last_grant <= 1'b1;
        end
        default: ;
      endcase
      // a restart wins over the sweep finishing on the same edge
      if (bus.clear_req) begin
        state <= CLEAR;
        clear_ptr <= '0;
      end
      drops <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  assign bus.s0_ready = !full[0];
  assign bus.s1_ready = !full[1];
  assign bus.vga_waddr = waddr;
  assign bus.dina = wdata;
  assign bus.wea = wen;
  assign bus.ena = wen;
  assign bus.busy = (state == CLEAR);
  assign bus.drop_count = drops;
endmodule

// File: tb/tb_map_write_arbiter.sv
// Scoreboard bench for map_write_arbiter on a reduced 2048-word map.
// s0 data keeps bit 7 low, s1 data keeps it high.
module tb_map_write_arbiter;
  localparam int AW = 19;
  localparam int DW = 8;
  localparam int N = 2048;

  typedef logic [AW+DW-1:0] ent_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  map_write_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  map_write_arbiter #(
    .AW(AW), .DW(DW), .MAP_WORDS(N),
    .FILL(8'hFF), .DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  ent_t q0[$];
  ent_t q1[$];
  int errors = 0;
  int checks = 0;
  int exp_clr = 0;
  bit in_clear = 1'b1;
  bit alt_mode = 1'b0;
  int alt_n = 0;
  bit prev_src = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  initial begin : monitor
    bit clr;
    bit src;
    ent_t e;
    forever begin
      @(posedge clk);
      clr = bus.clear_req;
      #1;
      if (!reset) continue;
      if (in_clear) begin
        chk("clear_word",
            32'({bus.wea, bus.ena, bus.dina, bus.vga_waddr}),
            32'({2'b11, 8'hFF, AW'(exp_clr)}));
        if (exp_clr == N - 1) in_clear = 1'b0;
        exp_clr++;
      end else if (bus.wea) begin
        src = bus.dina[7];
        if (src ? (q1.size() == 0) : (q0.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d data %0h want none",
                   bus.vga_waddr, bus.dina);
        end else begin
          e = src ? q1.pop_front() : q0.pop_front();
          chk(src ? "s1_write" : "s0_write",
              32'({bus.ena, bus.vga_waddr, bus.dina}), 32'({1'b1, e}));
        end
        if (alt_mode) begin
          if (alt_n > 0) chk("alternate", 32'(src), 32'(!prev_src));
          prev_src = src;
          alt_n++;
        end
      end
      if (clr) begin
        in_clear = 1'b1;
        exp_clr = 0;
      end
      chk("busy", 32'(bus.busy), 32'(in_clear));
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  task automatic idle_inputs();
    bus.clear_req = 1'b0;
    bus.s0_valid = 1'b0;
    bus.s1_valid = 1'b0;
    bus.s0_addr = '0;
    bus.s1_addr = '0;
    bus.s0_data = '0;
    bus.s1_data = 8'h80;
  endtask

  task automatic wait_clear(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.busy || in_clear) && n < N + 100);
    chk(name, 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((q0.size() + q1.size()) > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(q0.size() + q1.size()), 32'd0);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    bus.clear_req = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
  endtask

  task automatic check_reset_outs(input string name);
    chk(name, 32'({bus.wea, bus.ena, bus.dina, bus.vga_waddr}), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_drop", 32'(bus.drop_count), 32'd0);
    chk("rst_ready", 32'({bus.s0_ready, bus.s1_ready}), 32'b11);
  endtask

  initial begin : stim
    int i0;
    int i1;
    int n;
    bit saw0;
    bit saw1;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("rst_outs");

    // full sweep after reset release
    @(negedge clk);
    reset = 1'b1;
    wait_clear("clear1_done");
    @(negedge clk);
    chk("idle_wea", 32'(bus.wea), 32'd0);

    // single beat latency
    @(negedge clk);
    bus.s0_addr = AW'(1000);
    bus.s0_data = 8'h00;
    bus.s0_valid = 1'b1;
    q0.push_back({AW'(1000), 8'h00});
    chk("t2_ready_before", 32'(bus.s0_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("t2_ready_after", 32'(bus.s0_ready), 32'd1);
    chk("t2_no_write_yet", 32'(bus.wea), 32'd0);
    @(negedge clk);
    bus.s0_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("t2_write", 32'({bus.wea, bus.vga_waddr, bus.dina}),
        32'({1'b1, AW'(1000), 8'h00}));
    @(posedge clk);
    #1;
    chk("t2_single", 32'(bus.wea), 32'd0);

    // both sources streaming 8 beats
    alt_mode = 1'b1;
    alt_n = 0;
    saw0 = 1'b0;
    saw1 = 1'b0;
    i0 = 0;
    i1 = 0;
    n = 0;
    while ((i0 < 8 || i1 < 8) && n < 100) begin
      @(negedge clk);
      n++;
      bus.s0_valid = (i0 < 8);
      bus.s0_addr = AW'(100 + i0);
      bus.s0_data = 8'(8'h10 + i0);
      bus.s1_valid = (i1 < 8);
      bus.s1_addr = AW'(200 + i1);
      bus.s1_data = 8'(8'h90 + i1);
      if (!bus.s0_ready) saw0 = 1'b1;
      if (!bus.s1_ready) saw1 = 1'b1;
      if (i0 < 8 && bus.s0_ready) begin
        q0.push_back({bus.s0_addr, bus.s0_data});
        i0++;
      end
      if (i1 < 8 && bus.s1_ready) begin
        q1.push_back({bus.s1_addr, bus.s1_data});
        i1++;
      end
    end
    @(negedge clk);
    bus.s0_valid = 1'b0;
    bus.s1_valid = 1'b0;
    wait_drain("t3_drain");
    chk("t3_write_count", 32'(alt_n), 32'd16);
    chk("t3_s0_full_seen", 32'(saw0), 32'd1);
    chk("t3_s1_full_seen", 32'(saw1), 32'd1);
    alt_mode = 1'b0;

    // out-of-range drops and saturation
    @(negedge clk);
    bus.s1_valid = 1'b1;
    bus.s1_addr = AW'(N);
    bus.s1_data = 8'h80;
    @(negedge clk);
    bus.s1_addr = 19'h7FFFF;
    bus.s1_data = 8'h81;
    @(negedge clk);
    bus.s1_valid = 1'b0;
    chk("t4_drop2", 32'(bus.drop_count), 32'd2);
    @(negedge clk);
    chk("t4_no_write", 32'(bus.wea), 32'd0);
    bus.s0_valid = 1'b1;
    bus.s0_addr = AW'(N + 5);
    bus.s1_valid = 1'b1;
    bus.s1_addr = AW'(N + 9);
    @(negedge clk);
    bus.s0_valid = 1'b0;
    bus.s1_valid = 1'b0;
    chk("t4_drop_both", 32'(bus.drop_count), 32'd4);
    bus.s0_valid = 1'b1;
    bus.s1_valid = 1'b1;
    repeat (125) @(negedge clk);
    chk("t4_drop_254", 32'(bus.drop_count), 32'd254);
    @(negedge clk);
    chk("t4_sat_edge", 32'(bus.drop_count), 32'd255);
    bus.s0_valid = 1'b0;
    repeat (175) @(negedge clk);
    bus.s1_valid = 1'b0;
    chk("t4_sat_hold", 32'(bus.drop_count), 32'd255);

    // clear request with queued s0 writes
    pulse_clear();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      a = AW'(1500 + k);
      d = 8'(8'h40 + k);
      bus.s0_valid = 1'b1;
      bus.s0_addr = a;
      bus.s0_data = d;
      chk("t5_ready_open", 32'(bus.s0_ready), 32'd1);
      q0.push_back({a, d});
    end
    @(negedge clk);
    bus.s0_valid = 1'b0;
    chk("t5_ready_full", 32'(bus.s0_ready), 32'd0);
    repeat (480) @(negedge clk);
    chk("t5_mid_sweep", 32'(bus.busy), 32'd1);
    bus.clear_req = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    repeat (N - 2) @(negedge clk);
    bus.clear_req = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    chk("t5_restart_busy", 32'(bus.busy), 32'd1);
    wait_clear("t5_clear_done");
    wait_drain("t5_drain");

    // async reset with both FIFOs holding data
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      bus.s0_valid = 1'b1;
      bus.s0_addr = AW'(300 + k);
      bus.s0_data = 8'(8'h20 + k);
      bus.s1_valid = 1'b1;
      bus.s1_addr = AW'(400 + k);
      bus.s1_data = 8'(8'hA0 + k);
      q0.push_back({bus.s0_addr, bus.s0_data});
      q1.push_back({bus.s1_addr, bus.s1_data});
    end
    @(negedge clk);
    idle_inputs();
    chk("t6_pending", 32'(q0.size() + q1.size() > 0), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outs("t6_async_outs");
    q0.delete();
    q1.delete();
    in_clear = 1'b1;
    exp_clr = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_clear("t6_clear_done");
    repeat (20) @(negedge clk);
    chk("t6_quiet", 32'(bus.wea), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
